// File: rtl/muldiv_sequencer.sv
// Launches the shared multiplier or divider and sequences HI/LO writeback.
// Flags divide-by-zero and timeouts, and stalls the control unit while busy.
module muldiv_sequencer #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        req_div,
  input  logic [31:0] divisor,
  input  logic        hilo_read,
  input  logic        mult_done,
  input  logic        div_done,
  input  logic        div_zero,
  output logic        StartMult,
  output logic        StartDiv,
  output logic        MuxHighSel,
  output logic        MuxLowSel,
  output logic        WrHigh,
  output logic        WrLow,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic        div_zero_exc,
  output logic        timeout_err
);

  typedef enum logic [2:0] {
    IDLE, LAUNCH, WAIT, WRITE, EXC
  } state_e;

  localparam logic [CNT_W-1:0] TMO_LIM = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic             op_q, op_d;
  logic             mux_q, mux_d;
  logic             tmo_q, tmo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             sel_done;

  assign cnt_inc  = cnt_q + CNT_ONE;
  assign sel_done = op_q ? div_done : mult_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= 1'b0;
      mux_q   <= 1'b0;
      tmo_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      mux_q   <= mux_d;
      tmo_q   <= tmo_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    mux_d   = mux_q;
    tmo_d   = tmo_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          op_d  = req_div;
          cnt_d = '0;
          if (req_div && divisor == 32'd0) begin
            state_d = EXC;
            tmo_d   = 1'b0;
          end else begin
            state_d = LAUNCH;
            mux_d   = req_div;
          end
        end
      end
      LAUNCH: state_d = WAIT;
      WAIT: begin
        cnt_d = cnt_inc;
        // done outranks div_zero, which outranks timeout
        if (sel_done) begin
          state_d = WRITE;
        end else if (op_q && div_zero) begin
          state_d = EXC;
          tmo_d   = 1'b0;
        end else if (cnt_inc == TMO_LIM) begin
          state_d = EXC;
          tmo_d   = 1'b1;
        end
      end
      WRITE:   state_d = IDLE;
      EXC:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign StartMult    = (state_q == LAUNCH) && !op_q;
  assign StartDiv     = (state_q == LAUNCH) && op_q;
  assign MuxHighSel   = mux_q;
  assign MuxLowSel    = mux_q;
  assign WrHigh       = (state_q == WRITE);
  assign WrLow        = (state_q == WRITE);
  assign done         = (state_q == WRITE);
  assign div_zero_exc = (state_q == EXC) && !tmo_q;
  assign timeout_err  = (state_q == EXC) && tmo_q;
  assign busy         = (state_q != IDLE);
  assign stall        = busy && (hilo_read || req);

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Sequencer that shares the CPU's multiplier and divider and sequences their use. It sits between the main control unit and the mult/div units. For each multiply or divide request it launches the correct unit and waits for completion. It then drives the HI/LO source-mux selects and write enables, flags divide-by-zero and timeouts, and stalls the control unit while HI/LO are not yet valid.

## Interface
- TIMEOUT_CYCLES, 64: maximum WAIT cycles before a timeout error (valid range 2..255).
- CNT_W, 8: width of the WAIT-cycle counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

- Clk  in  1  system clock, all state updates on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- req  in  1  operation request from the control unit; sampled only in IDLE.
- req_div  in  1  operation select, sampled with req: 1 = div, 0 = mult.
- divisor  in  32  divisor operand (register B value), sampled with req.
- hilo_read  in  1  control unit is executing mfhi/mflo this cycle.
- mult_done  in  1  multiplier completion flag.
- div_done  in  1  divider completion flag.
- div_zero  in  1  divide-by-zero flag from the divider.
- StartMult  out  1  one-cycle multiplier start pulse.
- StartDiv  out  1  one-cycle divider start pulse.
- MuxHighSel  out  1  HI source-mux select: 0 = mult, 1 = div.
- MuxLowSel  out  1  LO source-mux select: 0 = mult, 1 = div.
- WrHigh  out  1  HI register write enable.
- WrLow  out  1  LO register write enable.
- busy  out  1  high in every state except IDLE.
- stall  out  1  equals busy AND (hilo_read OR req).
- done  out  1  one-cycle pulse, concurrent with the HI/LO write.
- div_zero_exc  out  1  one-cycle exception pulse for divide-by-zero.
- timeout_err  out  1  one-cycle exception pulse for a unit that never finished.

## Operation
States: IDLE, LAUNCH, WAIT, WRITE, EXC.

IDLE
- On req=1, latch op = req_div and clear the counter.
- If req_div=1 and divisor==0, go to EXC with cause = div-by-zero; no unit is started.
- Otherwise go to LAUNCH.

LAUNCH
- Assert StartDiv if op=1, StartMult if op=0, for exactly one cycle.
- Go to WAIT.

WAIT
- Counter increments once per WAIT cycle.
- Only the done flag of the selected unit counts; mult_done during a div (or div_done during a mult) is ignored.
- Selected done seen: go to WRITE.
- op=1 and div_zero=1: go to EXC with cause = div-by-zero.
- Counter reaches TIMEOUT_CYCLES with no done: go to EXC with cause = timeout.
- Priority when several occur in the same cycle: done > div_zero > timeout.

WRITE
- WrHigh=WrLow=1 and done=1, for one cycle.
- Go to IDLE.

EXC
- Pulse div_zero_exc or timeout_err (per cause) for one cycle.
- No HI/LO write.
- Go to IDLE.

Mux selects
- MuxHighSel = MuxLowSel = op from LAUNCH through WRITE.
- In IDLE and EXC they hold their last value.

Back-to-back operations
- A req arriving while busy is ignored: it is not queued.
- stall stays high so the control unit holds the instruction and re-presents req once the block returns to IDLE.

## Timing
- Reset low (asynchronous): state = IDLE, counter = 0, op = 0. All outputs 0, including mux selects, busy and stall.
- Reset release: the first active rising edge evaluates IDLE.
- Nominal sequence, with req sampled at edge 0:
  - cycle 1: LAUNCH (Start pulse).
  - cycles 2..k: WAIT, where done is first seen in cycle k.
  - cycle k+1: WRITE.
  - cycle k+2: IDLE, ready for a new req.
- Minimum latency (done seen in the first WAIT cycle): req to WrHigh is 3 cycles; busy is high for 3 cycles.
- Divide-by-zero detected at request: EXC in cycle 1; div_zero_exc pulses in cycle 1; IDLE in cycle 2.
- Timeout: EXC is entered on the cycle after the TIMEOUT_CYCLES-th WAIT cycle.
- Outputs are registered, or decoded only from the current state and op; they do not depend combinationally on the done inputs. Exception: stall is combinational on hilo_read and req.
- Reset asserted mid-operation: immediate IDLE, no pending write and no exception pulse. The unit is not restarted after reset is released.

## Test plan
- mult, req=1, req_div=0, mult_done rising 5 cycles after StartMult -> StartMult pulse in cycle 1; WrHigh=WrLow=1 and done=1 in cycle 7; MuxHighSel=MuxLowSel=0; busy high in cycles 1-7.
- div, divisor=0x00000007, div_done arriving in the first WAIT cycle -> StartDiv in cycle 1, WRITE in cycle 3, mux selects=1; back-to-back req in cycle 4 is accepted.
- div, divisor=0 -> no StartDiv; div_zero_exc=1 in cycle 1; WrHigh/WrLow stay 0; IDLE in cycle 2.
- TIMEOUT_CYCLES=4, mult with mult_done held low -> timeout_err in cycle 6; no write. Then assert div_done during a second mult -> ignored, and that mult also times out.
- hilo_read=1 during WAIT -> stall=1; hilo_read=1 in IDLE -> stall=0; req during WAIT -> stall=1 and no second StartMult/StartDiv.
- Reset pulled low during WAIT -> all outputs 0 asynchronously; after release, mult_done=1 produces no WrHigh/WrLow.
